// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the register file with scoreboard.
package regfile_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: issue sets, writeback clears, flush clears all.
// pend_cnt_o is registered from the same next-state vector, so it never lags the bits.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_en_i,
    input  logic [AW-1:0] clr_idx_i,
    input  logic          set_en_i,
    input  logic [AW-1:0] set_idx_i,
    input  logic          flush_i,
    input  logic [AW-1:0] rs1_i,
    input  logic [AW-1:0] rs2_i,
    output logic          rs1_busy_o,
    output logic          rs2_busy_o,
    output logic [AW:0]   pend_cnt_o
);
    logic [NREG-1:0] pend_q, pend_d;
    logic [AW:0]     cnt_q, cnt_d;

    // Clear before set so a same-cycle issue to the written register wins.
    always_comb begin
        pend_d = pend_q;
        if (flush_i) begin
            pend_d = '0;
        end else begin
            if (clr_en_i && clr_idx_i != AW'(REG_ZERO)) pend_d[clr_idx_i] = 1'b0;
            if (set_en_i && set_idx_i != AW'(REG_ZERO)) pend_d[set_idx_i] = 1'b1;
        end
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) cnt_d = cnt_d + (AW+1)'(pend_d[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rs1_busy_o = (rs1_i != AW'(REG_ZERO)) && pend_q[rs1_i];
    assign rs2_busy_o = (rs2_i != AW'(REG_ZERO)) && pend_q[rs2_i];
    assign pend_cnt_o = cnt_q;
endmodule

// File: rtl/regfile_sb.sv
// Integer register file (1W/2R, x0 = 0) with RAW scoreboard and flush.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data/busy to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wEn,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] write_data,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [AW:0]     pend_cnt
);
    logic [NREG-1:0][XLEN-1:0] regs_q;
    logic                      wr_nz;
    logic                      hit1, hit2;
    logic                      sb_busy1, sb_busy2;

    assign wr_nz = wEn && (rd != AW'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (rst)        regs_q     <= '0;
        else if (wr_nz) regs_q[rd] <= write_data;
    end

    regfile_scoreboard #(.NREG(NREG)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .clr_en_i   (wEn),
        .clr_idx_i  (rd),
        .set_en_i   (issue_en),
        .set_idx_i  (issue_rd),
        .flush_i    (flush),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .rs1_busy_o (sb_busy1),
        .rs2_busy_o (sb_busy2),
        .pend_cnt_o (pend_cnt)
    );

`ifdef REGFILE_BYPASS_EN
    assign hit1 = wr_nz && (rd == rs1);
    assign hit2 = wr_nz && (rd == rs2);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    // A forwarded read is completing its hazard this cycle, so it is never busy.
    assign read_data1 = hit1 ? write_data : (rs1 == AW'(REG_ZERO)) ? '0 : regs_q[rs1];
    assign read_data2 = hit2 ? write_data : (rs2 == AW'(REG_ZERO)) ? '0 : regs_q[rs2];
    assign rs1_busy   = sb_busy1 && !hit1;
    assign rs2_busy   = sb_busy2 && !hit2;
endmodule
